// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: transmitter state encoding,
// parity mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-time down-counter; tick is high while the count sits at zero.
// Shared between the UART transmitter and receiver.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CLKS_PER_BIT - 1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_stb.sv
// UART transmitter fed by a strobe/acknowledge byte stream; frames are
// start, 8 data bits LSB first, optional parity, one or two stop bits.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a byte
// ST_START  | start bit (line low)
// ST_DATA   | data bits 0..7, LSB first
// ST_PARITY | parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | stop bit(s), line high; may accept the next byte on its last cycle
module uart_tx_stb
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] i_data,
  input  logic       i_stb,
  output logic       i_ack,
  output logic       o_tx,
  output logic       o_busy
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_e  state, state_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic       stop_idx, stop_idx_nx;
  logic [7:0] data_q, data_nx;
  logic       tx_nx, busy_nx;
  logic       load, tick, ready;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK  (CLK),
    .RST_N(RST_N),
    .load (load),
    .tick (tick)
  );

  // Ready in the final cycle of the last stop bit gives gap-free back-to-back frames.
  assign ready = (state == ST_IDLE) ||
                 ((state == ST_STOP) && tick && (stop_idx == LAST_STOP));
  assign i_ack = i_stb & ready & RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_q   <= '0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_idx  <= bit_idx_nx;
      stop_idx <= stop_idx_nx;
      data_q   <= data_nx;
      o_tx     <= tx_nx;
      o_busy   <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bit_idx_nx  = bit_idx;
    stop_idx_nx = stop_idx;
    data_nx     = data_q;
    tx_nx       = o_tx;
    busy_nx     = o_busy;
    load        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
      end
      ST_START: begin
        if (tick) begin
          state_nx   = ST_DATA;
          bit_idx_nx = '0;
          tx_nx      = data_q[0];
          load       = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          load = 1'b1;
          if (bit_idx == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              state_nx = ST_PARITY;
              tx_nx    = parity_bit(data_q, PARITY);
            end else begin
              state_nx    = ST_STOP;
              stop_idx_nx = 1'b0;
              tx_nx       = 1'b1;
            end
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = data_q[bit_idx + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_nx    = ST_STOP;
          stop_idx_nx = 1'b0;
          tx_nx       = 1'b1;
          load        = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            state_nx = ST_IDLE;
            tx_nx    = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            stop_idx_nx = 1'b1;
            load        = 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase

    // Accepting a byte overrides whatever IDLE or the last stop cycle decided.
    if (i_ack) begin
      state_nx    = ST_START;
      data_nx     = i_data;
      bit_idx_nx  = '0;
      stop_idx_nx = 1'b0;
      tx_nx       = 1'b0;
      busy_nx     = 1'b1;
      load        = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_stb.sv
// Bench for uart_tx_stb: three instances (8N1, even/1 stop, odd/2 stops) at 4 clocks
// per bit, a per-cycle queue scoreboard, a vector table and hand sequences.
`timescale 1ns/1ps
module tb_uart_tx_stb;

  localparam int N = 4;

  typedef struct {
    int          g;
    logic [7:0]  d;
    logic [7:0]  junk;
    logic [11:0] exp_f;
    int          nbits;
    int          len;
  } vec_t;

  logic       clk, rst_n;
  logic       stb  [3];
  logic [7:0] din  [3];
  logic       ack  [3];
  logic       tx   [3];
  logic       busy [3];

  int errs   = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_of(input int g);
    case (g)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stops_of(input int g);
    return (g == 2) ? 2 : 1;
  endfunction

  function automatic int nbits_of(input int g);
    return 10 + ((par_of(g) != 0) ? 1 : 0) + stops_of(g) - 1;
  endfunction

  // Line bits in transmission order (bit 0 first); unused upper bits stay 1.
  function automatic logic [11:0] frame_of(input logic [7:0] d, input int g);
    logic [11:0] f;
    int ones;
    f    = '1;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par_of(g) == 2) f[9] = ((ones % 2) == 1);
    else if (par_of(g) == 1) f[9] = ((ones % 2) == 0);
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    uart_tx_stb #(
      .CLKS_PER_BIT(N),
      .PARITY      ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .i_data(din[g]),
      .i_stb (stb[g]),
      .i_ack (ack[g]),
      .o_tx  (tx[g]),
      .o_busy(busy[g])
    );

    // Front of the queue is the expected line value for the current cycle.
    bit exp_q[$];

    always @(posedge clk or negedge rst_n) begin : upd
      bit acc;
      logic [11:0] f;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        acc = (stb[g] === 1'b1) && (exp_q.size() <= 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
          f = frame_of(din[g], g);
          for (int k = 0; k < nbits_of(g); k++)
            for (int c = 0; c < N; c++) exp_q.push_back(f[k]);
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("sb_tx%0d", g),   tx[g],   (exp_q.size() > 0) ? exp_q[0] : 1'b1);
      check($sformatf("sb_busy%0d", g), busy[g], exp_q.size() > 0);
      check($sformatf("sb_ack%0d", g),  ack[g],
            (stb[g] === 1'b1) && (rst_n === 1'b1) && (exp_q.size() <= 1));
    end
  end

  task automatic wait_idle(input int g);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (busy[g] === 1'b0) done = 1'b1;
    end
    check($sformatf("idle_timeout%0d", g), done, 1);
  endtask

  task automatic send_frame(input int g, input logic [7:0] d, input logic [7:0] junk,
                            input logic [11:0] exp_f, input int nb, input int len);
    bit ok;
    int cnt;
    logic [11:0] obs, mask;
    ok  = 1'b0;
    cnt = 0;
    obs = '1;
    stb[g] = 1'b1;
    din[g] = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ack[g] === 1'b1) ok = 1'b1;
    end
    check($sformatf("accept%0d_%02h", g, d), ok, 1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    stb[g] = 1'b0;
    din[g] = junk;
    if (!ok) return;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy[g] !== 1'b1) break;
      if ((c % N) == (N / 2) && (c / N) < 12) obs[c / N] = tx[g];
      cnt++;
    end
    mask = 12'hFFF >> (12 - nb);
    check($sformatf("frame%0d_%02h", g, d), obs & mask, exp_f & mask);
    check($sformatf("busy_len%0d_%02h", g, d), cnt, len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [7];
    bit   ok;
    int   cnt, ack_at, g;
    logic tx40;
    logic [7:0] d, junk;

    vec[0] = '{g:0, d:8'hA5, junk:8'h5A, exp_f:{2'b11, 1'b1, 8'hA5, 1'b0},       nbits:10, len:40};
    vec[1] = '{g:1, d:8'h07, junk:8'hF8, exp_f:{1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, nbits:11, len:44};
    vec[2] = '{g:2, d:8'h07, junk:8'h00, exp_f:{1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, nbits:12, len:48};
    vec[3] = '{g:0, d:8'h55, junk:8'hAA, exp_f:{2'b11, 1'b1, 8'h55, 1'b0},       nbits:10, len:40};
    vec[4] = '{g:1, d:8'h00, junk:8'hFF, exp_f:{1'b1, 1'b1, 1'b0, 8'h00, 1'b0}, nbits:11, len:44};
    vec[5] = '{g:2, d:8'hFF, junk:8'h00, exp_f:{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0}, nbits:12, len:48};
    vec[6] = '{g:1, d:8'h81, junk:8'h7E, exp_f:{1'b1, 1'b1, 1'b0, 8'h81, 1'b0}, nbits:11, len:44};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stb[i] = 1'b0;
      din[i] = 8'h00;
    end
    stb[0] = 1'b1;
    din[0] = 8'h12;

    // Reset held with a byte offered: line idle, no acknowledge.
    repeat (3) @(negedge clk);
    check("rst_tx", tx[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_ack", ack[0], 0);
    #2 rst_n = 1'b1;
    #1 check("ack_after_release", ack[0], 1);
    @(posedge clk);
    #1;
    stb[0] = 1'b0;
    din[0] = 8'hC3;
    wait_idle(0);

    for (int i = 0; i < 7; i++)
      send_frame(vec[i].g, vec[i].d, vec[i].junk, vec[i].exp_f, vec[i].nbits, vec[i].len);

    // Back-to-back 0x00 then 0xFF with the strobe held throughout.
    stb[0] = 1'b1;
    din[0] = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) ok = 1'b1;
    end
    check("b2b_accept1", ok, 1);
    @(posedge clk);
    #1 din[0] = 8'hFF;
    cnt    = 0;
    ack_at = -1;
    tx40   = 1'bx;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy[0] !== 1'b1) break;
      cnt++;
      if (c == 40) tx40 = tx[0];
      if (ack[0] === 1'b1 && ack_at < 0) begin
        ack_at = c;
        @(posedge clk);
        #1;
        stb[0] = 1'b0;
        din[0] = 8'h5A;
      end
    end
    stb[0] = 1'b0;
    check("b2b_ack_cycle", ack_at, 39);
    check("b2b_busy_len", cnt, 80);
    check("b2b_no_gap_tx", tx40, 0);

    // Reset during data bit 3, then a clean frame.
    stb[0] = 1'b1;
    din[0] = 8'hE7;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) ok = 1'b1;
    end
    check("mid_accept", ok, 1);
    @(posedge clk);
    #1;
    stb[0] = 1'b0;
    din[0] = 8'h00;
    repeat (17) @(negedge clk);
    check("mid_tx_bit3", tx[0], 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx[0], 1);
    check("mid_rst_busy", busy[0], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send_frame(0, 8'h3C, 8'h00, {2'b11, 1'b1, 8'h3C, 1'b0}, 10, 40);

    // Random bytes on random instances, expectations from the frame rules.
    for (int i = 0; i < 30; i++) begin
      g    = $urandom_range(0, 2);
      d    = 8'($urandom);
      junk = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(g, d, junk, frame_of(d, g), nbits_of(g), nbits_of(g) * N);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_stb.md
# uart_tx_stb

UART transmitter that consumes bytes over the strobe/acknowledge stream interface used by the design's byte FIFOs and serialises them onto a single TX line. It sits at the FIFO's read side in the SDRAM-UART path: FIFO `o_data`/`o_stb`/`o_ack` connect directly to this block's `i_data`/`i_stb`/`i_ack`. Frame format is 8N1 by default, with optional parity and a second stop bit selected by parameter.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 2.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `i_data`  in  8  byte to transmit; sampled only on the accept edge.
- `i_stb`  in  1  byte valid; the source holds it until acknowledged.
- `i_ack`  out  1  combinational; high in the cycle the byte is accepted.
- `o_tx`  out  1  serial line, registered, idle high.
- `o_busy`  out  1  registered; high while a frame is in progress.

## Operation
- Handshake:
  - `ready` = (state == IDLE) OR (state == STOP AND last cycle of last stop bit).
  - `i_ack = i_stb & ready`.
  - A byte is accepted on the rising edge where `i_ack` = 1.
  - `i_data` is latched into the shift register on that edge. Later changes on `i_data` do not affect the frame.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: `o_tx` = 1, `o_busy` = 0. On accept, go to START.
  - START: `o_tx` = 0 for one bit time.
  - DATA: 8 bits, LSB first; bit index counter runs 0..7.
  - PARITY (only if `PARITY` ≠ 0):
    - even: the XOR of the 8 data bits;
    - odd: the inverse of that XOR.
  - STOP: `o_tx` = 1 for `STOP_BITS` bit times.
    - If accepted in the final cycle, go straight to START (zero-gap back-to-back frames).
    - Otherwise go to IDLE.
- Baud counter:
  - width `$clog2(CLKS_PER_BIT)`;
  - loads `CLKS_PER_BIT-1` at the start of every bit and counts down;
  - advances the bit/state at 0.
- Reset (any time, including mid-frame):
  - `o_tx` = 1, `o_busy` = 0, state = IDLE, counters = 0;
  - `i_ack` = 0 while `RST_N` is low;
  - any partially sent frame is abandoned, not resumed.

## Timing
- Accept edge E:
  - `o_tx` = 0 and `o_busy` = 1 from E onward;
  - start bit occupies cycles E..E+`CLKS_PER_BIT`-1.
- Every bit lasts exactly `CLKS_PER_BIT` cycles. Frame length = (10 + (`PARITY`≠0) + `STOP_BITS`-1) × `CLKS_PER_BIT` cycles.
- `o_busy` falls on the edge ending the last stop bit, unless a new byte is accepted on that edge; then it stays high.
- `i_ack` is combinational from `i_stb`; there is no loop with the FIFO because the FIFO's `o_stb` is registered.
- `i_stb` low during `ready`: no state change, `o_tx` stays 1.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
- One natural sub-module: `uart_baud_cnt`.
  - Loadable down-counter with a `tick` output at 0, parameterised by `CLKS_PER_BIT`.
  - The future UART receiver reuses it.
- Remaining FSM, shift register and parity logic live in `uart_tx_stb`. Target 150–250 lines total.

## Test plan
- Reset: hold `RST_N` = 0 with `i_stb` = 1 → `o_tx` = 1, `o_busy` = 0, `i_ack` = 0. Release → `i_ack` = 1 in the next cycle.
- Single byte, `CLKS_PER_BIT` = 4, no parity, data 0xA5:
  - one-cycle `i_ack`;
  - `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - `o_busy` high for exactly 40 cycles.
- Back-to-back: FIFO model holds `i_stb` with 0x00 then 0xFF → second start bit begins the cycle after the first stop bit ends, no idle-high gap; `o_busy` high continuously for 80 cycles.
- Parity, data 0x07:
  - `PARITY` = 2 → parity bit 1, frame 44 cycles;
  - `PARITY` = 1 → parity bit 0;
  - `STOP_BITS` = 2 → line high for 8 cycles after parity.
- Reset mid-frame during data bit 3 → `o_tx` = 1 immediately (asynchronous). After release, the next byte 0x3C is sent as a complete, correct frame.
- Data stability: change `i_data` from 0x55 to 0xAA in the cycle after accept → 0x55 is transmitted.
